// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor.
//   - State encoding of the control FSM. The fourth code (S_DONE+1) is unused
//     and is treated exactly like S_IDLE by the FSM and the status decode.
//   - calc_ovf: signed-overflow rule for A - B. Overflow can only happen when
//     the operands differ in sign, and it shows up as a result whose sign
//     differs from the minuend's sign.
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_SHIFT = 2'd1;
    localparam state_t S_DONE  = 2'd2;

    function automatic logic calc_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
//   Start/ready/done handshake and operand/result bus of the serial subtractor.
//   master: the issuing datapath (drives start, A, B)
//   slave : the subtractor (drives ready, busy, done, Diff, Bout, Ovf)
//   Signals:
//     start  request, accepted only while ready=1
//     A, B   minuend / subtrahend, sampled on the accepted start edge
//     ready  subtractor idle
//     busy   operation in progress (shifting or presenting the result)
//     done   one-cycle pulse; Diff/Bout/Ovf already hold the new result
//     Diff   (A - B) mod 2^WIDTH
//     Bout   final borrow (A < B unsigned)
//     Ovf    signed overflow of A - B
// -----------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             Ovf;

    modport master (
        output start, A, B,
        input  ready, busy, done, Diff, Bout, Ovf
    );

    modport slave (
        input  start, A, B,
        output ready, busy, done, Diff, Bout, Ovf
    );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor_full_subtractor
//   One-bit combinational full-subtractor cell: computes a - b - bin.
//   Ports:
//     a, b  operand bits
//     bin   borrow in from the previous (less significant) bit
//     d     difference bit
//     bout  borrow out to the next bit
// -----------------------------------------------------------------------------
module serial_subtractor_full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    // Borrow when b exceeds a, or when they are equal and a borrow is pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor: Diff = A - B, one bit per clock, LSB first, using a
//   single full-subtractor cell and a borrow flop.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  slave side of serial_subtractor_if (start/A/B in,
//          ready/busy/done/Diff/Bout/Ovf out)
//   Timing: start accepted at edge 0 -> WIDTH shift edges -> done high for
//   one cycle (cycle WIDTH+1) -> ready again in cycle WIDTH+2.
// -----------------------------------------------------------------------------
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_reg;
    logic [WIDTH-1:0] a_sr_reg;
    logic [WIDTH-1:0] b_sr_reg;
    logic [WIDTH-1:0] d_sr_reg;
    logic             borrow_reg;
    logic [CW-1:0]    count_reg;
    logic             a_msb_reg;
    logic             b_msb_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             bout_reg;
    logic             ovf_reg;

    logic             fs_d;
    logic             fs_bout;
    logic [WIDTH-1:0] d_sr_next;

    serial_subtractor_full_subtractor u_fs (
        .a    (a_sr_reg[0]),
        .b    (b_sr_reg[0]),
        .bin  (borrow_reg),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // New difference bit enters at the top, so after WIDTH shifts the LSB
    // computed first sits at bit 0.
    assign d_sr_next = {fs_d, d_sr_reg[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            a_sr_reg   <= '0;
            b_sr_reg   <= '0;
            d_sr_reg   <= '0;
            borrow_reg <= 1'b0;
            count_reg  <= '0;
            a_msb_reg  <= 1'b0;
            b_msb_reg  <= 1'b0;
            diff_reg   <= '0;
            bout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            case (state_reg)
                S_SHIFT: begin
                    a_sr_reg   <= {1'b0, a_sr_reg[WIDTH-1:1]};
                    b_sr_reg   <= {1'b0, b_sr_reg[WIDTH-1:1]};
                    d_sr_reg   <= d_sr_next;
                    borrow_reg <= fs_bout;
                    if (count_reg == LAST) begin
                        // Result registers are loaded on the edge that enters
                        // DONE so they are already valid while done is high.
                        state_reg <= S_DONE;
                        diff_reg  <= d_sr_next;
                        bout_reg  <= fs_bout;
                        ovf_reg   <= calc_ovf(a_msb_reg, b_msb_reg, fs_d);
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    // S_IDLE and the unused code behave identically.
                    state_reg <= S_IDLE;
                    if (bus.start) begin
                        state_reg  <= S_SHIFT;
                        a_sr_reg   <= bus.A;
                        b_sr_reg   <= bus.B;
                        d_sr_reg   <= '0;
                        borrow_reg <= 1'b0;
                        count_reg  <= '0;
                        a_msb_reg  <= bus.A[WIDTH-1];
                        b_msb_reg  <= bus.B[WIDTH-1];
                    end
                end
            endcase
        end
    end

    assign bus.busy  = (state_reg == S_SHIFT) || (state_reg == S_DONE);
    assign bus.ready = ~bus.busy;
    assign bus.done  = (state_reg == S_DONE);
    assign bus.Diff  = diff_reg;
    assign bus.Bout  = bout_reg;
    assign bus.Ovf   = ovf_reg;

endmodule
